// File: rtl/bht_update_unit.sv
// Write-side companion of the branch history table: buffers resolved outcomes as 2-bit counter
// updates in a small FIFO and keeps statistics. Optional same-index merging: BHT_UPD_COALESCE_EN.
module bht_update_unit #(
  parameter int BHT_SIZE   = 256,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [1:0]       res_pred_state,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [IDX_W-1:0] wr_idx,
  output logic [1:0]       wr_state,
  output logic             mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_reg, state_next;

  logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic [1:0]       fifo_st  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, last_ptr;
  logic [PTR_W:0]   count_reg;

  logic [IDX_W-1:0] res_idx;
  logic [1:0]       res_next;
  logic             full, empty, accept, pop, push, merge;

  // Upper/lower PC bits are not part of the index; parameter sanity folded in here.
  logic unused_bits;
  assign unused_bits = ^{res_pc[31:IDX_W+2], res_pc[1:0], (BHT_SIZE == (1 << IDX_W))};

  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic up);
    if (up) return (s == 2'b11) ? s : s + 2'd1;
    else    return (s == 2'b00) ? s : s - 2'd1;
  endfunction

  assign res_idx  = res_pc[IDX_W+1:2];
  assign res_next = sat_step(res_pred_state, res_taken);
  assign full     = (count_reg == DEPTH_CNT);
  assign empty    = (count_reg == '0);
  assign last_ptr = wr_ptr_reg - PTR_W'(1);

  assign wr_valid = (state_reg == ISSUE);
  assign wr_idx   = fifo_idx[rd_ptr_reg];
  assign wr_state = fifo_st[rd_ptr_reg];
  assign pop      = wr_valid && wr_ready;

`ifdef BHT_UPD_COALESCE_EN
  // Merge into the youngest entry unless it is the head leaving this very cycle.
  assign merge     = res_valid && !empty && (fifo_idx[last_ptr] == res_idx)
                     && !(pop && (last_ptr == rd_ptr_reg));
  assign res_ready = !full || merge;
`else
  assign merge     = 1'b0;
  assign res_ready = !full;
`endif

  assign accept = res_valid && res_ready;
  assign push   = accept && !merge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_idx[i] <= '0;
        fifo_st[i]  <= 2'b00;
      end
    end else begin
      if (push) begin
        fifo_idx[wr_ptr_reg] <= res_idx;
        fifo_st[wr_ptr_reg]  <= res_next;
        wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
      end else if (accept && merge) begin
        fifo_st[last_ptr] <= sat_step(fifo_st[last_ptr], res_taken);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // ISSUE exactly tracks a non-empty FIFO, so a push is visible one cycle later.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (push) state_next = ISSUE;
      ISSUE:   if (pop && (count_reg == (PTR_W+1)'(1)) && !push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= accept && (res_pred_state[1] != res_taken);
      if (accept && (branch_cnt != '1)) branch_cnt <= branch_cnt + 32'd1;
      if (accept && (res_pred_state[1] != res_taken) && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
